// File: rtl/axi_arbiter_r.sv
// axi_arbiter_r: round-robin read-channel arbiter for four AXI masters
// sharing one slave read port. One grant is held per burst (ADDR, DATA).
//
// Ports:
//   ACLK, ARESET            clock, async active-high reset
//   mN_ARVALID, mN_RREADY   per-master request / read-data ready (N=0..3)
//   m_ARREADY, m_RVALID,
//   m_RLAST                 shared slave-side handshake signals
//   mN_rgrnt                registered one-hot grant (N=0..3)
//   rgrnt_id                granted master index, 0 when idle
//   rd_busy                 high while a grant is held (ADDR or DATA)
//
// TCO is the clock-to-output delay of the original simulation model.
// This model is zero-delay, so TCO has no effect on behaviour.
module axi_arbiter_r #(
  parameter int TCO = 1
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       m0_ARVALID,
  input  logic       m1_ARVALID,
  input  logic       m2_ARVALID,
  input  logic       m3_ARVALID,
  input  logic       m0_RREADY,
  input  logic       m1_RREADY,
  input  logic       m2_RREADY,
  input  logic       m3_RREADY,
  input  logic       m_ARREADY,
  input  logic       m_RVALID,
  input  logic       m_RLAST,
  output logic       m0_rgrnt,
  output logic       m1_rgrnt,
  output logic       m2_rgrnt,
  output logic       m3_rgrnt,
  output logic [1:0] rgrnt_id,
  output logic       rd_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] gnt_id;
  logic [1:0] gnt_id_nx;
  logic [1:0] last_id;
  logic [1:0] last_id_nx;

  logic [3:0] grnt_q;
  logic [3:0] grnt_nx;
  logic [1:0] id_q;
  logic [1:0] id_nx;
  logic       busy_q;
  logic       busy_nx;

  logic [3:0] arvalid;
  logic [3:0] rready;
  logic [1:0] pick;
  logic       pick_vld;
  logic [1:0] cand;

  if (TCO < 0) begin : g_tco_neg
  end

  assign arvalid = {m3_ARVALID, m2_ARVALID,
                    m1_ARVALID, m0_ARVALID};
  assign rready  = {m3_RREADY, m2_RREADY,
                    m1_RREADY, m0_RREADY};

  // Rotating priority: last_id+1 first, last_id itself last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_id + k[1:0];
      if (!pick_vld && arvalid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    gnt_id_nx  = gnt_id;
    last_id_nx = last_id;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx  = ADDR;
          gnt_id_nx = pick;
        end
      end
      ADDR: begin
        // Requester withdrew: abandon without
        // moving the priority pointer.
        if (!arvalid[gnt_id]) begin
          state_nx = IDLE;
        end else if (m_ARREADY) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (m_RVALID && rready[gnt_id]
            && m_RLAST) begin
          state_nx   = IDLE;
          last_id_nx = gnt_id;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so
  // they change on the same edge as the FSM.
  always_comb begin
    busy_nx = (state_nx == ADDR)
           || (state_nx == DATA);
    grnt_nx = '0;
    id_nx   = '0;
    if (busy_nx) begin
      grnt_nx = 4'b0001 << gnt_id_nx;
      id_nx   = gnt_id_nx;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      gnt_id  <= '0;
      last_id <= 2'd3;
      grnt_q  <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      gnt_id  <= gnt_id_nx;
      last_id <= last_id_nx;
      grnt_q  <= grnt_nx;
      id_q    <= id_nx;
      busy_q  <= busy_nx;
    end
  end

  assign m0_rgrnt = grnt_q[0];
  assign m1_rgrnt = grnt_q[1];
  assign m2_rgrnt = grnt_q[2];
  assign m3_rgrnt = grnt_q[3];
  assign rgrnt_id = id_q;
  assign rd_busy  = busy_q;

endmodule

// File: tb/tb_axi_arbiter_r.sv
// tb_axi_arbiter_r: directed scenarios plus randomized traffic,
// checked every cycle against a burst-level reference model.
module tb_axi_arbiter_r;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic [3:0] arv = '0;
  logic [3:0] rrdy = '0;
  logic       arready = 1'b0;
  logic       rvalid = 1'b0;
  logic       rlast = 1'b0;
  logic       g0, g1, g2, g3;
  logic [1:0] rid;
  logic       busy;

  int passed = 0;
  int total = 0;

  // Reference model: who owns the read channel,
  // whether its address was accepted, and who finished last.
  int owner = -1;
  bit in_data = 0;
  int last = 3;

  always #5 ACLK = ~ACLK;

  axi_arbiter_r #(.TCO(1)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_ARVALID(arv[0]), .m1_ARVALID(arv[1]),
    .m2_ARVALID(arv[2]), .m3_ARVALID(arv[3]),
    .m0_RREADY(rrdy[0]), .m1_RREADY(rrdy[1]),
    .m2_RREADY(rrdy[2]), .m3_RREADY(rrdy[3]),
    .m_ARREADY(arready), .m_RVALID(rvalid),
    .m_RLAST(rlast),
    .m0_rgrnt(g0), .m1_rgrnt(g1),
    .m2_rgrnt(g2), .m3_rgrnt(g3),
    .rgrnt_id(rid), .rd_busy(busy)
  );

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic model_reset();
    owner = -1;
    in_data = 0;
    last = 3;
  endtask

  task automatic model_upd();
    if (ARESET) begin
      model_reset();
    end else if (owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last + k) % 4;
        if (owner < 0 && arv[c]) begin
          owner = c;
          in_data = 0;
        end
      end
    end else if (!in_data) begin
      if (!arv[owner]) owner = -1;
      else if (arready) in_data = 1;
    end else if (rvalid && rrdy[owner] && rlast) begin
      last = owner;
      owner = -1;
      in_data = 0;
    end
  endtask

  task automatic check_model();
    int eg;
    eg = (owner < 0) ? 0 : (1 << owner);
    chk("grant", int'({g3, g2, g1, g0}), eg);
    chk("rgrnt_id", int'(rid), (owner < 0) ? 0 : owner);
    chk("rd_busy", int'(busy), (owner < 0) ? 0 : 1);
  endtask

  task automatic step();
    @(posedge ACLK);
    model_upd();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    arv = '0; rrdy = '0;
    arready = 0; rvalid = 0; rlast = 0;
    model_reset();
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    check_model();
  endtask

  int rise_cyc[8];
  int rise_id[8];
  int nr;
  int beat;
  bit prev_busy;
  bit prev_data;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset and first arbitration
    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_grants", int'({g3, g2, g1, g0}), 0);
    arv = 4'hF;
    step();
    chk("first_g0", int'(g0), 1);
    chk("first_id", int'(rid), 0);
    chk("first_busy", int'(busy), 1);

    // Round robin with 4-beat bursts
    do_reset();
    arv = 4'hF; rrdy = 4'hF;
    arready = 1; rvalid = 1;
    nr = 0; beat = 0; prev_busy = 0;
    for (int i = 0; i < 8; i++) begin
      rise_cyc[i] = -1;
      rise_id[i] = -1;
    end
    for (int cyc = 1; cyc <= 30; cyc++) begin
      rlast = in_data && (beat == 3);
      prev_data = in_data;
      step();
      if (prev_data && in_data) beat++;
      else beat = 0;
      if (!prev_busy && busy && nr < 8) begin
        rise_cyc[nr] = cyc;
        rise_id[nr] = int'(rid);
        nr++;
      end
      prev_busy = busy;
    end
    for (int i = 0; i < 5; i++)
      chk("rr_order", rise_id[i], exp_order[i]);
    chk("rr_first_cyc", rise_cyc[0], 1);
    for (int i = 1; i < 5; i++)
      chk("rr_gap", rise_cyc[i] - rise_cyc[i-1], 6);

    // Master 2 held in DATA until its RREADY
    do_reset();
    arv = 4'b0100; arready = 1;
    step();
    step();
    chk("m2_in_data", int'(g2), 1);
    rvalid = 1; rlast = 1; rrdy = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("m2_held", int'(g2), 1);
    end
    rrdy = 4'b0100;
    step();
    chk("m2_done_busy", int'(busy), 0);
    rvalid = 0; rlast = 0; rrdy = 0;
    arv = 4'hF;
    step();
    chk("after_m2_id", int'(rid), 3);

    // Abandoned address phase keeps master 1 first
    do_reset();
    arv = 4'b0001; arready = 1;
    step();
    step();
    rvalid = 1; rlast = 1; rrdy = 4'b0001;
    step();
    rvalid = 0; rlast = 0; rrdy = 0;
    arready = 0; arv = 4'b0010;
    step();
    chk("m1_addr", int'(g1), 1);
    step();
    arv = 4'b0000;
    step();
    chk("abandon_grants", int'({g3, g2, g1, g0}), 0);
    chk("abandon_busy", int'(busy), 0);
    arv = 4'hF;
    step();
    chk("rereq_id", int'(rid), 1);

    // Other masters' RREADY ignored
    do_reset();
    arv = 4'b0001; arready = 1;
    step();
    step();
    rvalid = 1; rlast = 1; rrdy = 4'b0010;
    arv = 4'hF;
    step();
    step();
    chk("m0_kept", int'(g0), 1);

    // Async reset mid-DATA on master 3
    do_reset();
    arv = 4'b1000; arready = 1;
    step();
    step();
    rvalid = 1; rlast = 0; rrdy = 4'b1000;
    step();
    chk("m3_data", int'(g3), 1);
    #2;
    ARESET = 1'b1;
    model_reset();
    #1;
    chk("arst_grants", int'({g3, g2, g1, g0}), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    arv = 4'b0001; rvalid = 0; rrdy = 0;
    step();
    chk("post_arst_g0", int'(g0), 1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      arv = 4'($urandom);
      rrdy = 4'($urandom);
      arready = ($urandom_range(0, 1) == 1);
      rvalid = ($urandom_range(0, 3) != 0);
      rlast = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
